// File: rtl/puf_pkg.sv
// Shared definitions for the PUF evaluation blocks: FSM encoding,
// sample-select codes and a width helper for parameter-derived counters.
package puf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_EVAL = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam int SEL_POS = 0;
   localparam int SEL_NEG = 1;
   localparam int SEL_XOR = 2;

   // Bits needed to encode values 0..value-1.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >>> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/rsp_vote_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module popcount
   import puf_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]              bits,
   output logic [clog2(WIDTH+1)-1:0]     count
);

   localparam int OW = clog2(WIDTH + 1);

   always_comb begin
      count = '0;
      for (int i = 0; i < WIDTH; i++) begin
         count = count + OW'(bits[i]);
      end
   end

endmodule

// File: rtl/rsp_vote.sv
// Repeats response generation NUM_REPEAT times and majority-votes each bit,
// reporting which bits flipped between repeats and how many did.
module rsp_vote
   import puf_pkg::*;
#(
   parameter int RSP_WIDTH  = 32,
   parameter int NUM_REPEAT = 15,
   parameter int SAMPLE_SEL = SEL_POS,
   parameter int TIMEOUT    = 4096
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   output logic                               gen_req,
   input  logic                               rsp_valid,
   input  logic [RSP_WIDTH-1:0]               rsp_pos,
   input  logic [RSP_WIDTH-1:0]               rsp_neg,
   output logic                               busy,
   output logic                               done,
   output logic                               err,
   output logic [RSP_WIDTH-1:0]               key,
   output logic [RSP_WIDTH-1:0]               unstable,
   output logic [clog2(RSP_WIDTH+1)-1:0]      unstable_cnt
);

   localparam int CW = clog2(NUM_REPEAT + 1);
   localparam int TW = clog2(TIMEOUT);
   localparam int PW = clog2(RSP_WIDTH + 1);

   localparam logic [CW-1:0] HALF     = CW'(NUM_REPEAT / 2);
   localparam logic [CW-1:0] FULL     = CW'(NUM_REPEAT);
   localparam logic [CW-1:0] LAST_REP = CW'(NUM_REPEAT - 1);
   localparam logic [TW-1:0] TERM     = TW'(TIMEOUT - 1);

   state_t                state;
   state_t                state_next;
   logic [CW-1:0]         rep_cnt;
   logic [TW-1:0]         tmo_cnt;
   logic [RSP_WIDTH-1:0]  sample;
   logic [RSP_WIDTH-1:0]  key_next;
   logic [RSP_WIDTH-1:0]  unstable_next;
   logic [PW-1:0]         cnt_next;
   logic                  accept_start;
   logic                  accept_rsp;
   logic                  tmo_hit;

   assign accept_start = (state == ST_IDLE) && start;
   assign accept_rsp   = (state == ST_WAIT) && rsp_valid;
   // A response arriving on the terminal count still counts, so no abort then.
   assign tmo_hit      = (state == ST_WAIT) && !rsp_valid && (tmo_cnt == TERM);

   always_comb begin
      case (SAMPLE_SEL)
         SEL_NEG: sample = rsp_neg;
         SEL_XOR: sample = rsp_pos ^ rsp_neg;
         default: sample = rsp_pos;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      gen_req    = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            gen_req    = 1'b1;
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (rsp_valid) begin
               state_next = (rep_cnt == LAST_REP) ? ST_EVAL : ST_REQ;
            end else if (tmo_cnt == TERM) begin
               state_next = ST_DONE;
            end
         end
         ST_EVAL: begin
            state_next = ST_DONE;
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            busy       = 1'b0;
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || accept_start) begin
         rep_cnt <= '0;
         tmo_cnt <= '0;
      end else if (accept_rsp) begin
         rep_cnt <= rep_cnt + CW'(1);
         tmo_cnt <= '0;
      end else if (state == ST_WAIT) begin
         tmo_cnt <= tmo_cnt + TW'(1);
      end
   end

   for (genvar i = 0; i < RSP_WIDTH; i++) begin : g_bit
      logic [CW-1:0] vote;

      always_ff @(posedge clk) begin
         if (rst || accept_start) begin
            vote <= '0;
         end else if (accept_rsp) begin
            vote <= vote + CW'(sample[i]);
         end
      end

      assign key_next[i]      = vote > HALF;
      assign unstable_next[i] = (vote != '0) && (vote != FULL);
   end

   popcount #(
      .WIDTH (RSP_WIDTH)
   ) u_popcount (
      .bits  (unstable_next),
      .count (cnt_next)
   );

   // Results persist through IDLE; only a new start clears the error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         err          <= 1'b0;
         key          <= '0;
         unstable     <= '0;
         unstable_cnt <= '0;
      end else if (accept_start) begin
         err <= 1'b0;
      end else if (tmo_hit) begin
         err          <= 1'b1;
         key          <= '0;
         unstable     <= '0;
         unstable_cnt <= '0;
      end else if (state == ST_EVAL) begin
         key          <= key_next;
         unstable     <= unstable_next;
         unstable_cnt <= cnt_next;
      end
   end

endmodule

// File: tb/tb_rsp_vote.sv
// Bench for rsp_vote: two instances (direct and XOR sampling) driven in
// lockstep by a responder, checked against hand tables and a voting model.
module tb_rsp_vote;

   localparam int NR  = 3;
   localparam int TMO = 16;
   localparam int W   = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          rsp_valid;
   logic [W-1:0]  rsp_pos;
   logic [W-1:0]  rsp_neg;

   logic          gen_req0, busy0, done0, err0;
   logic [W-1:0]  key0, unst0;
   logic [5:0]    cnt0;
   logic          gen_req2, busy2, done2, err2;
   logic [W-1:0]  key2, unst2;
   logic [5:0]    cnt2;

   rsp_vote #(.RSP_WIDTH(W), .NUM_REPEAT(NR), .SAMPLE_SEL(0), .TIMEOUT(TMO)) dut_pos (
      .clk(clk), .rst(rst), .start(start), .gen_req(gen_req0),
      .rsp_valid(rsp_valid), .rsp_pos(rsp_pos), .rsp_neg(rsp_neg),
      .busy(busy0), .done(done0), .err(err0),
      .key(key0), .unstable(unst0), .unstable_cnt(cnt0)
   );

   rsp_vote #(.RSP_WIDTH(W), .NUM_REPEAT(NR), .SAMPLE_SEL(2), .TIMEOUT(TMO)) dut_xor (
      .clk(clk), .rst(rst), .start(start), .gen_req(gen_req2),
      .rsp_valid(rsp_valid), .rsp_pos(rsp_pos), .rsp_neg(rsp_neg),
      .busy(busy2), .done(done2), .err(err2),
      .key(key2), .unstable(unst2), .unstable_cnt(cnt2)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] p0, p1, p2;
      logic [31:0] n0, n1, n2;
      logic [7:0]  lat;
      logic [31:0] key0, unst0;
      logic [7:0]  cnt0;
      logic [31:0] key2, unst2;
   } vec_t;

   vec_t         vecs[6];
   int           n_checks = 0;
   int           n_pass   = 0;
   int           reqs;
   bit           aborted;
   logic [31:0]  seq_pos[3];
   logic [31:0]  seq_neg[3];

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Majority and disagreement per bit, counted directly from the samples.
   function automatic void model(input logic [31:0] s[3], output logic [31:0] k, output logic [31:0] u);
      int ones;
      k = '0;
      u = '0;
      for (int i = 0; i < W; i++) begin
         ones = 0;
         for (int r = 0; r < NR; r++) ones = ones + int'(s[r][i]);
         k[i] = (2 * ones > NR);
         u[i] = (ones != 0) && (ones != NR);
      end
   endfunction

   task automatic check_result(input string tag, input logic [31:0] ek0, input logic [31:0] eu0,
                               input logic [31:0] ek2, input logic [31:0] eu2, input logic e_err);
      check_output($sformatf("%s.key_pos", tag), key0, ek0);
      check_output($sformatf("%s.unst_pos", tag), unst0, eu0);
      check_output($sformatf("%s.cnt_pos", tag), cnt0, $countones(eu0));
      check_output($sformatf("%s.key_xor", tag), key2, ek2);
      check_output($sformatf("%s.unst_xor", tag), unst2, eu2);
      check_output($sformatf("%s.cnt_xor", tag), cnt2, $countones(eu2));
      check_output($sformatf("%s.err_pos", tag), err0, e_err);
      check_output($sformatf("%s.err_xor", tag), err2, e_err);
   endtask

   // Starts one evaluation and plays the generator: answers the first
   // n_answer requests lat cycles after each gen_req.  stray holds start high
   // and pulses rsp_valid with inverted data in every REQ cycle; rst_at>0
   // resets in the first WAIT cycle of that request.
   task automatic apply_stimulus(input int n_answer, input int lat, input bit stray, input int rst_at);
      int  cd, answered, last_valid, wait_entry, done_idx;
      bit  fin;
      reqs = 0; answered = 0; cd = 0; last_valid = -100; wait_entry = -100;
      done_idx = -1; fin = 0; aborted = 0;
      @(negedge clk);
      start = 1'b1;
      for (int k = 0; k < 300 && !fin; k++) begin
         @(negedge clk);
         if (!stray) start = 1'b0;
         rsp_valid = 1'b0;
         if (k == 0) begin
            check_output("busy_after_start", busy0, 1);
            check_output("req_after_start", gen_req0, 1);
            check_output("err_cleared", err0, 0);
         end
         if (done0) begin
            fin = 1; done_idx = k; start = 1'b0;
            if (answered == NR) check_output("done_latency", done_idx - last_valid, 2);
            else check_output("timeout_latency", done_idx - wait_entry, TMO);
         end else if (gen_req0) begin
            reqs++;
            if (reqs > 1) check_output("req_after_rsp", k - last_valid, 1);
            wait_entry = k + 1;
            cd = lat;
            if (stray) begin
               rsp_valid = 1'b1;
               rsp_pos   = ~seq_pos[0];
               rsp_neg   = ~seq_neg[0];
            end
         end else if (cd > 0) begin
            cd--;
            if (cd == 0 && answered < n_answer) begin
               rsp_valid  = 1'b1;
               rsp_pos    = seq_pos[answered];
               rsp_neg    = seq_neg[answered];
               answered++;
               last_valid = k;
            end
         end
         if (rst_at != 0 && reqs == rst_at && k == wait_entry) begin
            rst = 1'b1; rsp_valid = 1'b0; start = 1'b0;
            @(negedge clk);
            check_output("rst.busy", busy0, 0);
            check_output("rst.gen_req", gen_req0, 0);
            check_output("rst.done", done0, 0);
            check_output("rst.key", key0, 0);
            check_output("rst.unst", unst0, 0);
            check_output("rst.cnt", cnt0, 0);
            check_output("rst.key_xor", key2, 0);
            rst = 1'b0; fin = 1; aborted = 1;
         end
      end
      rsp_valid = 1'b0;
      start     = 1'b0;
      if (!fin) check_output("eval_budget", 0, 1);
      else if (!aborted) begin
         check_output("busy_in_done", busy0, 1);
         check_output("done_lockstep", done2, 1);
         @(negedge clk);
         check_output("done_one_cycle", done0, 0);
         check_output("busy_after_done", busy0, 0);
      end
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] ek0, eu0, ek2, eu2;
      logic [31:0] xs[3];
      int          idle_act;

      vecs[0] = '{p0:32'hA5A5A5A5, p1:32'hA5A5A5A5, p2:32'hA5A5A5A5, n0:32'h0, n1:32'h0, n2:32'h0,
                  lat:8'd1, key0:32'hA5A5A5A5, unst0:32'h0, cnt0:8'd0, key2:32'hA5A5A5A5, unst2:32'h0};
      vecs[1] = '{p0:32'hFFFFFFFF, p1:32'h00000000, p2:32'h0000FFFF, n0:32'h0, n1:32'h0, n2:32'h0,
                  lat:8'd2, key0:32'h0000FFFF, unst0:32'hFFFFFFFF, cnt0:8'd32, key2:32'h0000FFFF, unst2:32'hFFFFFFFF};
      vecs[2] = '{p0:32'hFFFF0000, p1:32'hFFFF0000, p2:32'hFFFF0000, n0:32'h0F0F0F0F, n1:32'h0F0F0F0F, n2:32'h0F0F0F0F,
                  lat:8'd3, key0:32'hFFFF0000, unst0:32'h0, cnt0:8'd0, key2:32'hF0F00F0F, unst2:32'h0};
      vecs[3] = '{p0:32'h12345678, p1:32'h12345678, p2:32'h87654321, n0:32'h0, n1:32'h0, n2:32'h0,
                  lat:8'd1, key0:32'h12345678, unst0:32'h95511559, cnt0:8'd14, key2:32'h12345678, unst2:32'h95511559};
      vecs[4] = '{p0:32'h0, p1:32'h0, p2:32'h0, n0:32'hFFFFFFFF, n1:32'hFFFFFFFF, n2:32'h0,
                  lat:8'd4, key0:32'h0, unst0:32'h0, cnt0:8'd0, key2:32'hFFFFFFFF, unst2:32'hFFFFFFFF};
      vecs[5] = '{p0:32'h0F0F0F0F, p1:32'h0F0F0F0F, p2:32'hF0F0F0F0, n0:32'h0, n1:32'h0, n2:32'h0,
                  lat:8'd16, key0:32'h0F0F0F0F, unst0:32'hFFFFFFFF, cnt0:8'd32, key2:32'h0F0F0F0F, unst2:32'hFFFFFFFF};

      rst = 1'b1; start = 1'b0; rsp_valid = 1'b0; rsp_pos = '0; rsp_neg = '0;
      repeat (3) @(negedge clk);
      check_output("reset.busy", busy0, 0);
      check_output("reset.gen_req", gen_req0, 0);
      check_output("reset.done", done0, 0);
      check_output("reset.err", err0, 0);
      check_output("reset.key", key0, 0);
      check_output("reset.unst", unst0, 0);
      check_output("reset.cnt", cnt0, 0);
      check_output("reset.busy_xor", busy2, 0);
      rst = 1'b0;

      // Hand-computed vectors; the last one answers exactly on the timeout terminal count.
      for (int i = 0; i < 6; i++) begin
         seq_pos[0] = vecs[i].p0; seq_pos[1] = vecs[i].p1; seq_pos[2] = vecs[i].p2;
         seq_neg[0] = vecs[i].n0; seq_neg[1] = vecs[i].n1; seq_neg[2] = vecs[i].n2;
         apply_stimulus(NR, int'(vecs[i].lat), 1'b0, 0);
         check_output($sformatf("vec%0d.reqs", i), reqs, NR);
         check_output($sformatf("vec%0d.cnt_table", i), cnt0, vecs[i].cnt0);
         check_result($sformatf("vec%0d", i), vecs[i].key0, vecs[i].unst0, vecs[i].key2, vecs[i].unst2, 1'b0);
      end

      for (int it = 0; it < 12; it++) begin
         logic [31:0] base;
         base = $urandom;
         for (int r = 0; r < NR; r++) begin
            seq_pos[r] = base ^ ($urandom & $urandom & $urandom);
            seq_neg[r] = $urandom;
            xs[r]      = seq_pos[r] ^ seq_neg[r];
         end
         model(seq_pos, ek0, eu0);
         model(xs, ek2, eu2);
         apply_stimulus(NR, int'($urandom_range(1, 5)), 1'b0, 0);
         check_output($sformatf("rand%0d.reqs", it), reqs, NR);
         check_result($sformatf("rand%0d", it), ek0, eu0, ek2, eu2, 1'b0);
      end

      // Generator never answers: abort after TMO WAIT cycles with zeroed results.
      seq_pos[0] = 32'hDEADBEEF; seq_pos[1] = 32'hDEADBEEF; seq_pos[2] = 32'hDEADBEEF;
      seq_neg[0] = 32'h0;        seq_neg[1] = 32'h0;        seq_neg[2] = 32'h0;
      apply_stimulus(0, 1, 1'b0, 0);
      check_output("tmo0.reqs", reqs, 1);
      check_result("tmo0", 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);

      // Two answers then silence; the next start must clear err.
      apply_stimulus(2, 2, 1'b0, 0);
      check_output("tmo2.reqs", reqs, NR);
      check_result("tmo2", 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);

      seq_pos[0] = vecs[1].p0; seq_pos[1] = vecs[1].p1; seq_pos[2] = vecs[1].p2;
      apply_stimulus(NR, 2, 1'b1, 0);
      check_output("stray.reqs", reqs, NR);
      check_result("stray", 32'h0000FFFF, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFFFFFF, 1'b0);
      idle_act = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (gen_req0 || busy0) idle_act++;
      end
      check_output("stray.no_second_eval", idle_act, 0);

      seq_pos[0] = 32'hA5A5A5A5; seq_pos[1] = 32'hA5A5A5A5; seq_pos[2] = 32'hA5A5A5A5;
      apply_stimulus(NR, 5, 1'b0, 2);
      check_output("rst_mid.aborted", aborted, 1);
      apply_stimulus(NR, 2, 1'b0, 0);
      check_output("after_rst.reqs", reqs, NR);
      check_result("after_rst", 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
